// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and default-divisor helper for the UART baud tick generator
package uart_pkg;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int MIN_DIV = 2;
  function automatic longint unsigned default_div_q(input longint unsigned clk_hz,
                                                    input longint unsigned baud,
                                                    input longint unsigned os,
                                                    input int frac_w);
    return (clk_hz << frac_w) / (baud * os);
  endfunction
endpackage

// File: rtl/uart_frac_divider.sv
// uart_frac_divider: fractional period counter with shadow/active divisor registers
module uart_frac_divider
  import uart_pkg::*;
#(
  parameter int DIV_W = 20,
  parameter int FRAC_W = 4,
  parameter logic [DIV_W-1:0] DEF_INT = DIV_W'(MIN_DIV),
  parameter logic [FRAC_W-1:0] DEF_FRAC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [DIV_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  input  logic              div_load_i,
  input  logic              sync_clear_i,
  output logic              wrap_o,
  output logic              div_pending_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d, act_int_q, act_int_d, shd_int_q, shd_int_d, ld_int;
  logic [FRAC_W-1:0] acc_q, acc_d, act_frac_q, act_frac_d, shd_frac_q, shd_frac_d;
  logic [FRAC_W:0] frac_sum;
  logic pend_q, pend_d, swap;
  always_comb begin
    ld_int = (div_int_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_int_i;
    frac_sum = {1'b0, acc_q} + {1'b0, act_frac_q};
    // a carry out of the accumulator stretches this period by one cycle
    wrap_o = en_i & (frac_sum[FRAC_W] ? cnt_q == act_int_q : cnt_q == act_int_q - 1'b1);
    shd_int_d = div_load_i ? ld_int : shd_int_q;
    shd_frac_d = div_load_i ? div_frac_i : shd_frac_q;
    swap = sync_clear_i ? (pend_q | div_load_i) : (wrap_o & pend_q);
    act_int_d = swap ? shd_int_d : act_int_q;
    act_frac_d = swap ? shd_frac_d : act_frac_q;
    pend_d = ~swap & (pend_q | div_load_i);
    cnt_d = (sync_clear_i | wrap_o) ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
    acc_d = sync_clear_i ? '0 : wrap_o ? frac_sum[FRAC_W-1:0] : acc_q;
  end
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
      act_int_q <= DEF_INT;
      act_frac_q <= DEF_FRAC;
      shd_int_q <= DEF_INT;
      shd_frac_q <= DEF_FRAC;
      pend_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      act_int_q <= act_int_d;
      act_frac_q <= act_frac_d;
      shd_int_q <= shd_int_d;
      shd_frac_q <= shd_frac_d;
      pend_q <= pend_d;
    end
  end
  assign div_pending_o = pend_q;
endmodule

// File: rtl/uart_baud_tick_gen.sv
// uart_baud_tick_gen: fractional baud divider producing oversample, bit and mid-bit enable ticks
module uart_baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 83_333_333,
  parameter int BAUD = 9600,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DIV_W = 20,
  parameter int FRAC_W = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en_i,
  input  logic [DIV_W-1:0]              div_int_i,
  input  logic [FRAC_W-1:0]             div_frac_i,
  input  logic                          div_load_i,
  input  logic                          sync_clear_i,
  output logic                          tick_os_o,
  output logic                          tick_bit_o,
  output logic                          tick_mid_o,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase_o,
  output logic                          div_pending_o
);
  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam longint unsigned DEF_Q = default_div_q(64'(CLK_HZ), 64'(BAUD), 64'(OVERSAMPLE), FRAC_W);
  localparam longint unsigned DEF_I = DEF_Q >> FRAC_W;
  localparam logic [DIV_W-1:0] DEF_INT = (DEF_I < 64'(MIN_DIV)) ? DIV_W'(MIN_DIV) : DIV_W'(DEF_I);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_Q);
  logic wrap, fire;
  logic [PH_W-1:0] phase_q, phase_d;
  logic tick_os_q, tick_os_d, tick_bit_q, tick_bit_d, tick_mid_q, tick_mid_d;
  uart_frac_divider #(
    .DIV_W(DIV_W),
    .FRAC_W(FRAC_W),
    .DEF_INT(DEF_INT),
    .DEF_FRAC(DEF_FRAC)
  ) u_div (
    .clk(clk),
    .rst_n(rst_n),
    .en_i(en_i),
    .div_int_i(div_int_i),
    .div_frac_i(div_frac_i),
    .div_load_i(div_load_i),
    .sync_clear_i(sync_clear_i),
    .wrap_o(wrap),
    .div_pending_o(div_pending_o)
  );
  always_comb begin
    fire = wrap & ~sync_clear_i;
    phase_d = sync_clear_i ? '0 : fire ? phase_q + 1'b1 : phase_q;
    tick_os_d = fire;
    tick_bit_d = fire & (phase_q == PH_W'(OVERSAMPLE - 1));
    tick_mid_d = fire & (phase_q == PH_W'(OVERSAMPLE / 2 - 1));
  end
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      phase_q <= '0;
      tick_os_q <= 1'b0;
      tick_bit_q <= 1'b0;
      tick_mid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      tick_os_q <= tick_os_d;
      tick_bit_q <= tick_bit_d;
      tick_mid_q <= tick_mid_d;
    end
  end
  assign tick_os_o = tick_os_q;
  assign tick_bit_o = tick_bit_q;
  assign tick_mid_o = tick_mid_q;
  assign os_phase_o = phase_q;
endmodule

// File: tb/tb_uart_baud_tick_gen.sv
// tb_uart_baud_tick_gen: directed vectors and corner sequences for the baud tick generator
module tb_uart_baud_tick_gen;
  logic clk = 1'b0, rst_n = 1'b1, en = 1'b1, div_load = 1'b0, sync_clear = 1'b0;
  logic [19:0] div_int = '0;
  logic [3:0] div_frac = '0;
  logic tick_os, tick_bit, tick_mid, div_pending;
  logic [3:0] os_phase;
  int checks = 0, failures = 0, nbit = 0, nmid = 0;
  typedef struct {
    int dint;
    int dfrac;
    int n;
    int total;
    int short_len;
    int nlong;
    int nbit;
    int nmid;
  } vec_t;
  vec_t v[6];
  always #5 clk = ~clk;
  uart_baud_tick_gen dut (
    .clk(clk),
    .rst_n(rst_n),
    .en_i(en),
    .div_int_i(div_int),
    .div_frac_i(div_frac),
    .div_load_i(div_load),
    .sync_clear_i(sync_clear),
    .tick_os_o(tick_os),
    .tick_bit_o(tick_bit),
    .tick_mid_o(tick_mid),
    .os_phase_o(os_phase),
    .div_pending_o(div_pending)
  );
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick_os && n < 20000);
    if (!tick_os) check("tick_timeout", n, -1);
    nbit += int'(tick_bit);
    nmid += int'(tick_mid);
  endtask
  task automatic load_clear(input int di, input int df);
    div_int = 20'(di);
    div_frac = 4'(df);
    div_load = 1'b1;
    sync_clear = 1'b1;
    step();
    div_load = 1'b0;
    sync_clear = 1'b0;
  endtask
  initial begin
    int n, sum, nl, mn, ph, bad, first;
    v[0] = '{542, 8, 16, 8680, 542, 8, 1, 1};
    v[1] = '{3, 4, 16, 52, 3, 4, 1, 1};
    v[2] = '{4, 0, 16, 64, 4, 0, 1, 1};
    v[3] = '{0, 0, 8, 16, 2, 0, 0, 1};
    v[4] = '{1, 15, 16, 47, 2, 15, 1, 1};
    v[5] = '{10, 0, 16, 160, 10, 0, 1, 1};
    repeat (3) step();
    check("rst_tick_os", int'(tick_os), 0);
    check("rst_tick_bit", int'(tick_bit), 0);
    check("rst_phase", int'(os_phase), 0);
    check("rst_pending", int'(div_pending), 0);
    rst_n = 1'b0;
    sum = 0; nl = 0; nbit = 0; nmid = 0; first = 0;
    for (int i = 0; i < 16; i++) begin
      wait_tick(n);
      if (i == 0) first = n;
      sum += n;
      if (n == 543) nl++;
    end
    check("def_first", first, 542);
    check("def_total", sum, 8680);
    check("def_long", nl, 8);
    check("def_bits", nbit, 1);
    check("def_mids", nmid, 1);
    repeat (100) step();
    div_int = 20'd4; div_frac = 4'd0; div_load = 1'b1;
    step();
    div_load = 1'b0;
    check("ml_pending_set", int'(div_pending), 1);
    wait_tick(n);
    check("ml_old_period", n, 441);
    check("ml_pending_clr", int'(div_pending), 0);
    for (int i = 0; i < 3; i++) begin
      wait_tick(n);
      check("ml_new_period", n, 4);
    end
    for (int i = 0; i < 40 && !tick_bit; i++) wait_tick(n);
    check("ml_bit_found", int'(tick_bit), 1);
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      wait_tick(n);
      sum += n;
    end
    check("ml_bit_interval", sum, 64);
    check("ml_bit_at_16", int'(tick_bit), 1);
    for (int k = 0; k < 6; k++) begin
      load_clear(v[k].dint, v[k].dfrac);
      check("vec_clr_phase", int'(os_phase), 0);
      check("vec_clr_pending", int'(div_pending), 0);
      sum = 0; nl = 0; mn = 1 << 30; nbit = 0; nmid = 0;
      for (int i = 0; i < v[k].n; i++) begin
        wait_tick(n);
        sum += n;
        if (n > v[k].short_len) nl++;
        if (n < mn) mn = n;
      end
      check($sformatf("vec%0d_total", k), sum, v[k].total);
      check($sformatf("vec%0d_long", k), nl, v[k].nlong);
      check($sformatf("vec%0d_bits", k), nbit, v[k].nbit);
      check($sformatf("vec%0d_mids", k), nmid, v[k].nmid);
      check($sformatf("vec%0d_min_ge2", k), int'(mn >= 2), 1);
      check($sformatf("vec%0d_phase", k), int'(os_phase), v[k].n % 16);
    end
    load_clear(10, 0);
    for (int i = 0; i < 3; i++) wait_tick(n);
    repeat (2) step();
    sync_clear = 1'b1;
    step();
    sync_clear = 1'b0;
    check("sc_no_tick", int'(tick_os), 0);
    check("sc_phase", int'(os_phase), 0);
    for (int i = 0; i < 8; i++) begin
      wait_tick(n);
      if (i == 0) check("sc_first_period", n, 10);
      check($sformatf("sc_mid_at_%0d", i + 1), int'(tick_mid), int'(i == 7));
    end
    wait_tick(n);
    repeat (9) step();
    sync_clear = 1'b1;
    step();
    sync_clear = 1'b0;
    check("sc_suppress_tick", int'(tick_os), 0);
    check("sc_suppress_phase", int'(os_phase), 0);
    wait_tick(n);
    check("sc_after_suppress", n, 10);
    wait_tick(n);
    ph = int'(os_phase);
    repeat (3) step();
    en = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick_os || tick_bit || tick_mid || int'(os_phase) != ph) bad++;
    end
    check("en_hold", bad, 0);
    en = 1'b1;
    wait_tick(n);
    check("en_resume_period", n, 7);
    check("en_resume_phase", int'(os_phase), (ph + 1) % 16);
    div_int = 20'd4; div_frac = 4'd0; div_load = 1'b1;
    step();
    div_load = 1'b0;
    check("rm_pending_before", int'(div_pending), 1);
    #2 rst_n = 1'b1;
    #1;
    check("rm_tick_os", int'(tick_os), 0);
    check("rm_phase", int'(os_phase), 0);
    check("rm_pending", int'(div_pending), 0);
    #2 rst_n = 1'b0;
    wait_tick(n);
    check("rm_first_period", n, 542);
    wait_tick(n);
    check("rm_second_period", n, 543);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_baud_tick_gen.md
# uart_baud_tick_gen

Programmable UART baud-rate tick generator with fractional divisor. It emits single-cycle clock-enable ticks at the oversample rate, plus bit-rate and mid-bit ticks, instead of a derived toggling clock. The divisor is reloadable at runtime without glitches, and the phase can be re-aligned by the receiver on a start-bit edge. It sits between the system clock domain and the UART TX/RX engines, which run on `clk` and qualify their logic with these ticks.

## Interface
- `CLK_HZ`, default 83_333_333: system clock frequency.
- `BAUD`, default 9600: reset baud rate.
- `OVERSAMPLE`, default 16: ticks per bit. Power of two, minimum 4.
- `DIV_W`, default 20: width of the integer divisor.
- `FRAC_W`, default 4: width of the fractional divisor.
- `clk  in  1`: system clock.
- `rst_n  in  1`: reset, asynchronous, active-high.
- `en  in  1`: run enable. When 0, all counters hold and no ticks are issued.
- `div_int  in  DIV_W`: integer part of the clocks per oversample tick.
- `div_frac  in  FRAC_W`: fractional part, in units of 1/2^FRAC_W.
- `div_load  in  1`: one-cycle strobe that captures `div_int`/`div_frac` into the shadow register.
- `sync_clear  in  1`: restarts the period, phase and fractional accumulator.
- `tick_os  out  1`: one-cycle oversample tick.
- `tick_bit  out  1`: one-cycle tick, coincides with the `tick_os` whose phase wraps to 0.
- `tick_mid  out  1`: one-cycle tick, coincides with the `tick_os` that sets the phase to OVERSAMPLE/2.
- `os_phase  out  $clog2(OVERSAMPLE)`: current oversample phase.
- `div_pending  out  1`: a loaded divisor is waiting to take effect.

## Operation
- Reset values:
  - Active divisor and shadow divisor = DEFAULT_DIV_Q = floor(CLK_HZ·2^FRAC_W/(BAUD·OVERSAMPLE)), split into an integer part and a fractional part.
  - Counter = 0, frac_acc = 0, os_phase = 0.
  - All ticks = 0, div_pending = 0.
- Period per tick: the integer part, extended by one cycle when frac_acc + frac carries out of FRAC_W bits.
  - frac_acc updates modulo 2^FRAC_W at every tick_os.
  - Average period = int + frac/2^FRAC_W.
- Integer clamp: an integer part below 2 is treated as 2. This applies on load, so the active value is never below 2.
- Counter: counts 0 up to period−1 while en=1. On the terminal count it wraps to 0, and a tick is issued on the following cycle (ticks are registered outputs).
- os_phase increments modulo OVERSAMPLE on each tick_os.
- div_load:
  - Captures the inputs into the shadow register and sets div_pending.
  - The shadow is copied to the active divisor at the next counter wrap; div_pending clears then.
  - A second load before that wrap overwrites the shadow (last write wins).
- sync_clear:
  - Counter = 0, os_phase = 0, frac_acc = 0.
  - Any tick that would have been issued on the following cycle is suppressed.
  - If div_pending, the shadow divisor is applied immediately.
  - When sync_clear and div_load arrive in the same cycle, the newly loaded value is applied immediately.
- en=0: counter, phase and accumulator hold; ticks are forced to 0. div_load and sync_clear remain functional.
- Reset mid-operation: everything returns to the reset values asynchronously. Any pending load is discarded.

## Timing
- After reset release, or after sync_clear, with en=1: the first tick_os occurs exactly P cycles later, where P is the first period.
- tick_os width: exactly 1 cycle. It is never asserted on consecutive cycles because the period is at least 2.
- tick_bit rate: once per OVERSAMPLE tick_os.
- tick_mid: the tick_os with the OVERSAMPLE/2 phase transition. For an RX engine, tick_mid after a sync_clear at the start-bit edge falls at mid-bit.
- os_phase changes in the same cycle tick_os is high.
- Divisor change latency: takes effect at the first counter wrap after the load, so the period in progress completes at the old value.

## Structure
- Shared `uart_pkg`:
  - OVERSAMPLE default.
  - Function computing DEFAULT_DIV_Q from CLK_HZ, BAUD, OVERSAMPLE and FRAC_W.
  - Constant MIN_DIV = 2.
- Sub-module `uart_frac_divider`:
  - Contains the counter, fractional accumulator and shadow/active divisor registers.
  - Outputs the raw wrap pulse.
- Top level: adds the phase counter, tick registers and en gating.

## Test plan
- Defaults with CLK_HZ=83_333_333, BAUD=9600: DEFAULT_DIV_Q = 8680, i.e. int 542, frac 8.
  - Expect 16 tick_os spanning 8680 cycles: eight periods of 542 and eight of 543.
  - Expect one tick_bit per 16 tick_os.
- Load int=4, frac=0 mid-period:
  - The old period completes first.
  - Then tick_os every 4 cycles and tick_bit every 64 cycles.
  - div_pending is high until the switch.
- Load int=3, frac=4: over 16 tick_os the total is 52 cycles, with exactly 4 periods of length 4.
- sync_clear on cycle 2 of a 10-cycle period:
  - No tick on the next cycle.
  - os_phase = 0.
  - Next tick_os 10 cycles later, and tick_mid on the 8th tick_os.
- en low for 20 cycles:
  - No ticks; counter and phase are frozen.
  - After en returns high, the period resumes from where it stopped.
  - Assert rst_n mid-period: all outputs 0 immediately, divisor back to the default.
- Load int=0 or int=1: the divisor behaves as 2, so tick_os fires every 2 cycles and is never continuously high.
